// File: rtl/hr_pkg.sv
// Shared types and constants for the heart-rate measurement path.
package hr_pkg;

  localparam int unsigned MS_PER_MIN_X4 = 240000;  // 60000 ms/min times the 4-interval average
  localparam int unsigned AVG_DEPTH     = 4;
  localparam int unsigned BPM_MAX       = 255;

  localparam int unsigned INTERVAL_W    = 11;
  localparam int unsigned SUM_W         = 13;
  localparam int unsigned DIVIDEND_W    = 18;

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, DIVIDE} hr_state_e;

  typedef logic [INTERVAL_W-1:0] interval_t;
  typedef logic [SUM_W-1:0]      sum_t;

endpackage

// File: rtl/beat_rate_meter_divider.sv
// Generic restoring shift-subtract divider with start/busy/done handshake.
// The first quotient bit is resolved on the start edge, so a DIVIDEND_W-bit
// quotient is ready (done_o high) exactly DIVIDEND_W cycles after start.
module seq_divider #(
  parameter int unsigned DIVIDEND_W = 18,
  parameter int unsigned DIVISOR_W  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, done_q;

  logic [DIVISOR_W-1:0]  rem_in, dvs_in;
  logic [DIVIDEND_W-1:0] quo_in;
  logic [DIVISOR_W:0]    trial, diff;
  logic                  load;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    load   = start_i && !busy_q;
    rem_in = load ? '0 : rem_q;
    quo_in = load ? dividend_i : quo_q;
    dvs_in = load ? divisor_i : dvs_q;
    trial  = {rem_in, quo_in[DIVIDEND_W-1]};
    diff   = trial - {1'b0, dvs_in};
    if (trial >= {1'b0, dvs_in}) begin
      rem_d = diff[DIVISOR_W-1:0];
      quo_d = {quo_in[DIVIDEND_W-2:0], 1'b1};
    end else begin
      rem_d = trial[DIVISOR_W-1:0];
      quo_d = {quo_in[DIVIDEND_W-2:0], 1'b0};
    end
  end

  // Iteration control: load on start, step while busy, pulse done after the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvs_q  <= divisor_i;
        cnt_q  <= CNT_W'(DIVIDEND_W - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/beat_rate_meter.sv
// Beat-rate meter: synchronises the peak flag, times accepted beats in ms,
// averages the last four intervals and converts the sum to BPM.
module beat_rate_meter
  import hr_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 40000,
  parameter int unsigned REFRACT_MS = 300,
  parameter int unsigned TIMEOUT_MS = 2000,
  parameter int unsigned LED_MS     = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       peak_in,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       bpm_locked,
  output logic       beat_led,
  output logic [7:0] reject_cnt
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LED_W  = $clog2(LED_MS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(LED_MS - 1);
  localparam interval_t         REFRACT_I = interval_t'(REFRACT_MS);
  localparam interval_t         TIMEOUT_I = interval_t'(TIMEOUT_MS);
  localparam logic [2:0]        FILL_FULL = 3'(AVG_DEPTH);

  // Saturate the 18-bit quotient into the 8-bit display range.
  function automatic logic [7:0] sat_bpm(input logic [DIVIDEND_W-1:0] q);
    return (q > DIVIDEND_W'(BPM_MAX)) ? 8'(BPM_MAX) : q[7:0];
  endfunction

  logic              peak_meta_q, peak_sync_q, peak_prev_q, beat_evt_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic              ms_tick;
  interval_t         interval_q;
  logic              led_q;
  logic [LED_W-1:0]  led_ms_q;

  hr_state_e         state_q;
  interval_t         ring_q [AVG_DEPTH];
  sum_t              sum_q, sum_d;
  logic [2:0]        fill_q, fill_d;
  logic [1:0]        wr_ptr_q;
  logic [7:0]        bpm_q, reject_q;
  logic              bpm_valid_q, locked_q;

  logic              in_track, accept, reject, arm, timeout, interval_clr;
  logic              div_start, div_busy, div_done;
  logic [DIVIDEND_W-1:0] div_quot;

  // Two-flop synchroniser followed by a registered rising-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_meta_q <= 1'b0;
      peak_sync_q <= 1'b0;
      peak_prev_q <= 1'b0;
      beat_evt_q  <= 1'b0;
    end else begin
      peak_meta_q <= peak_in;
      peak_sync_q <= peak_meta_q;
      peak_prev_q <= peak_sync_q;
      beat_evt_q  <= peak_sync_q & ~peak_prev_q;
    end
  end

  assign ms_tick = (tick_cnt_q == TICK_LAST);

  // Free-running millisecond prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= ms_tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Beat qualification and next-state arithmetic for the averaging window.
  always_comb begin
    in_track     = (state_q == ARMED) || (state_q == TRACK);
    accept       = beat_evt_q && in_track && (interval_q >= REFRACT_I);
    reject       = beat_evt_q && ((in_track && (interval_q < REFRACT_I)) || (state_q == DIVIDE));
    arm          = beat_evt_q && (state_q == IDLE);
    timeout      = in_track && !beat_evt_q && (interval_q == TIMEOUT_I);
    interval_clr = accept || arm;
    sum_d        = sum_q + sum_t'(interval_q) - sum_t'(ring_q[wr_ptr_q]);
    fill_d       = (fill_q == FILL_FULL) ? fill_q : fill_q + 3'd1;
    div_start    = accept && (fill_d == FILL_FULL) && !div_busy;
  end

  // Interval timer; a tick coinciding with the clearing beat belongs to the new interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interval_q <= '0;
    end else if (interval_clr) begin
      interval_q <= ms_tick ? interval_t'(1) : '0;
    end else if (ms_tick && (interval_q != TIMEOUT_I)) begin
      interval_q <= interval_q + interval_t'(1);
    end
  end

  // Beat LED stretch, restarted by every accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q    <= 1'b0;
      led_ms_q <= '0;
    end else if (accept) begin
      led_q    <= 1'b1;
      led_ms_q <= '0;
    end else if (led_q && ms_tick) begin
      if (led_ms_q == LED_LAST) begin
        led_q    <= 1'b0;
        led_ms_q <= '0;
      end else begin
        led_ms_q <= led_ms_q + LED_W'(1);
      end
    end
  end

  // Measurement FSM with ring buffer, running sum and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      reject_q    <= '0;
    end else begin
      bpm_valid_q <= 1'b0;
      if (reject && (reject_q != 8'hFF)) reject_q <= reject_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (arm) state_q <= ARMED;
        end
        ARMED, TRACK: begin
          if (accept) begin
            ring_q[wr_ptr_q] <= interval_q;
            sum_q            <= sum_d;
            fill_q           <= fill_d;
            wr_ptr_q         <= wr_ptr_q + 2'd1;
            state_q          <= (fill_d == FILL_FULL) ? DIVIDE : TRACK;
          end else if (timeout) begin
            for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            wr_ptr_q    <= '0;
            bpm_q       <= '0;
            bpm_valid_q <= 1'b1;
            locked_q    <= 1'b0;
            state_q     <= IDLE;
          end
        end
        DIVIDE: begin
          if (div_done) begin
            bpm_q       <= sat_bpm(div_quot);
            bpm_valid_q <= 1'b1;
            locked_q    <= 1'b1;
            state_q     <= TRACK;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  seq_divider #(
    .DIVIDEND_W(DIVIDEND_W),
    .DIVISOR_W (SUM_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start_i   (div_start),
    .dividend_i(DIVIDEND_W'(MS_PER_MIN_X4)),
    .divisor_i (sum_d),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_quot)
  );

  assign bpm        = bpm_q;
  assign bpm_valid  = bpm_valid_q;
  assign bpm_locked = locked_q;
  assign beat_led   = led_q;
  assign reject_cnt = reject_q;

endmodule

// File: tb/tb_beat_rate_meter.sv
// Directed bench for beat_rate_meter with a shortened ms tick.
module tb_beat_rate_meter;

  localparam int TICK = 2;    // clk cycles per ms tick in this bench
  localparam int HOLD = 10;   // default peak_in high time in cycles
  localparam int LED_MS = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       peak_in;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       bpm_locked;
  logic       beat_led;
  logic [7:0] reject_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int last_bpm = -1;
  int last_lock = -1;
  int led_run = 0;
  int led_len = 0;
  int led_pulses = 0;

  always #5 clk = ~clk;

  beat_rate_meter #(
    .TICK_DIV  (TICK),
    .REFRACT_MS(300),
    .TIMEOUT_MS(2000),
    .LED_MS    (LED_MS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .peak_in   (peak_in),
    .bpm       (bpm),
    .bpm_valid (bpm_valid),
    .bpm_locked(bpm_locked),
    .beat_led  (beat_led),
    .reject_cnt(reject_cnt)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bpm_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_bpm  <= int'(bpm);
      last_lock <= int'(bpm_locked);
    end
    if (beat_led) begin
      led_run <= led_run + 1;
    end else if (led_run != 0) begin
      led_len    <= led_run;
      led_run    <= 0;
      led_pulses <= led_pulses + 1;
    end
  end

  // One peak: rise now, hold, then idle so the next rise is gap_ms later.
  task automatic beat(input int gap_ms, input int hold);
    peak_in = 1'b1;
    repeat (hold) @(posedge clk);
    #2 peak_in = 1'b0;
    repeat (gap_ms * TICK - hold) @(posedge clk);
    #2;
  endtask

  task automatic idle_ms(input int ms);
    repeat (ms * TICK) @(posedge clk);
    #2;
  endtask

  int v0, p0;
  int gaps [6] = '{750, 800, 800, 800, 800, 800};
  int exps [6] = '{80, 80, 78, 77, 76, 75};

  initial begin
    reset   = 1'b0;
    peak_in = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_bpm", int'(bpm), 0);
    check("rst_valid", int'(bpm_valid), 0);
    check("rst_locked", int'(bpm_locked), 0);
    check("rst_led", int'(beat_led), 0);
    check("rst_reject", int'(reject_cnt), 0);
    reset = 1'b0;
    @(posedge clk);
    #2;

    // Four beats, then reset five cycles into the division of the fifth.
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) beat(1000, HOLD);
    peak_in = 1'b1;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_bpm", int'(bpm), 0);
    check("abort_locked", int'(bpm_locked), 0);
    check("abort_led", int'(beat_led), 0);
    check("abort_valid", int'(bpm_valid), 0);
    @(posedge clk);
    #2 peak_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    check("abort_no_valid", valid_cnt - v0, 0);

    // Relock at 1000 ms: first result on the fifth pulse.
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) beat(1000, HOLD);
    check("relock_early", valid_cnt - v0, 0);
    beat(1000, HOLD);
    check("lock60_cnt", valid_cnt - v0, 1);
    check("lock60_bpm", last_bpm, 60);
    check("lock60_lockflag", last_lock, 1);
    check("lock60_locked_out", int'(bpm_locked), 1);
    beat(100, HOLD);
    check("steady60_cnt", valid_cnt - v0, 2);
    check("steady60_bpm", last_bpm, 60);

    // Extra peak 100 ms after a beat is rejected without disturbing timing.
    beat(900, HOLD);
    check("refract_reject", int'(reject_cnt), 1);
    check("refract_no_valid", valid_cnt - v0, 2);
    beat(1900, HOLD);
    check("after_reject_cnt", valid_cnt - v0, 3);
    check("after_reject_bpm", last_bpm, 60);

    // Silence reaches 2000 ms after the last accepted beat.
    idle_ms(200);
    check("timeout_cnt", valid_cnt - v0, 4);
    check("timeout_bpm", last_bpm, 0);
    check("timeout_lockflag", last_lock, 0);
    check("timeout_locked_out", int'(bpm_locked), 0);

    // From idle: four beats silent, then 750 ms steady, then 800 ms.
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) beat(750, HOLD);
    check("post_timeout_silent", valid_cnt - v0, 0);
    for (int k = 0; k < 6; k++) begin
      beat(gaps[k], HOLD);
      check($sformatf("rate_step%0d_cnt", k), valid_cnt - v0, k + 1);
      check($sformatf("rate_step%0d_bpm", k), last_bpm, exps[k]);
    end
    check("rate_locked", int'(bpm_locked), 1);
    check("rate_reject", int'(reject_cnt), 1);

    // Peak held high for 500 ms: a single beat and a single LED stretch.
    v0 = valid_cnt;
    p0 = led_pulses;
    beat(800, 500 * TICK);
    check("hold_valid_cnt", valid_cnt - v0, 1);
    check("hold_bpm", last_bpm, 75);
    check("hold_reject", int'(reject_cnt), 1);
    check("hold_led_pulses", led_pulses - p0, 1);
    check("hold_led_len_in_range",
          ((led_len >= (LED_MS - 1) * TICK + 1) && (led_len <= LED_MS * TICK)) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
